imem_loader: RTL and testbench

- Writer side of the byte-addressed instruction memory that the fetch stage reads.
- Receives a program image as a valid/ready byte stream: header byte, big-endian instruction bytes, XOR checksum byte.
- Writes the image into an internal 8-bit-wide memory and exposes a combinational fetch read port indexed by the 8-bit word program counter.
- Holds the core (core_hold) until a load completes with a good checksum.

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Purpose: loads a program image from a byte stream into the fetch instruction memory; holds the core until a good load.
// Latency: each accepted byte is written to memory on its accept edge; fetch_instr is a zero-latency combinational read.
// Backpressure: in_ready is high only in HDR/DATA/CSUM; bytes offered in IDLE/DONE are left with the upstream source.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] fetch_pc,
   output logic [31:0]       fetch_instr,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   output logic              core_hold,
   output logic [ADDR_W:0]   words_loaded
);

   // Byte capacity of the array and the width of a byte address into it.
   localparam int BYTES = 4 << ADDR_W;
   localparam int CNT_W = ADDR_W + 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nx;

   logic [CNT_W-1:0]  byte_cnt;     // next byte address to write in DATA
   logic [7:0]        csum_acc;     // running XOR of the data bytes
   logic [ADDR_W-1:0] word_last;    // header value: index of the last word (N-1)
   logic              accept;       // a byte transfers on this edge
   logic              last_byte;    // current DATA byte is the final one of the image

   // Instruction memory: deliberately not reset so an image survives a reset.
   logic [7:0]        mem [0:BYTES-1];

   assign accept    = in_valid && in_ready;
   assign last_byte = (byte_cnt == {word_last, 2'b11});

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and per-state handshake/status outputs.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      load_busy = 1'b0;
      load_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (load_start) begin
               state_nx = S_HDR;
            end
         end
         S_HDR: begin
            in_ready  = 1'b1;
            load_busy = 1'b1;
            if (in_valid) begin
               state_nx = S_DATA;
            end
         end
         S_DATA: begin
            in_ready  = 1'b1;
            load_busy = 1'b1;
            if (in_valid && last_byte) begin
               state_nx = S_CSUM;
            end
         end
         S_CSUM: begin
            in_ready  = 1'b1;
            load_busy = 1'b1;
            if (in_valid) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            load_done = 1'b1;
            if (load_start) begin
               state_nx = S_HDR;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // The core may only run once a load has finished with a matching checksum.
   assign core_hold = !((state == S_DONE) && !load_err);

   // Load bookkeeping: header capture, byte counter, checksum and word count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt     <= '0;
         csum_acc     <= '0;
         word_last    <= '0;
         words_loaded <= '0;
         load_err     <= 1'b0;
      end else begin
         case (state)
            S_HDR: begin
               if (accept) begin
                  word_last    <= ADDR_W'(in_data);
                  byte_cnt     <= '0;
                  csum_acc     <= '0;
                  words_loaded <= '0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  csum_acc <= csum_acc ^ in_data;
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  // A word is complete when its fourth byte lands.
                  if (byte_cnt[1:0] == 2'b11) begin
                     words_loaded <= words_loaded + (ADDR_W+1)'(1);
                  end
               end
            end
            S_CSUM: begin
               if (accept) begin
                  load_err <= (in_data != csum_acc);
               end
            end
            S_DONE: begin
               if (load_start) begin
                  load_err <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Memory write port: one byte per accepted DATA transfer, no wrap needed.
   always_ff @(posedge clk) begin
      if ((state == S_DATA) && accept) begin
         mem[byte_cnt] <= in_data;
      end
   end

   // Big-endian fetch: lowest byte address is the most significant byte.
   assign fetch_instr = {mem[{fetch_pc, 2'b00}],
                         mem[{fetch_pc, 2'b01}],
                         mem[{fetch_pc, 2'b10}],
                         mem[{fetch_pc, 2'b11}]};

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: directed stimulus for imem_loader with a completion scoreboard and direct fetch/status checks.
// Latency: stimulus pushes the expected load outcome before streaming; the monitor pops it when load_done rises.
// Backpressure: the byte driver holds each byte until in_ready is seen, bounded by a cycle budget.
module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_start = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [ADDR_W-1:0] fetch_pc = '0;
   logic [31:0]       fetch_instr;
   logic              load_busy;
   logic              load_done;
   logic              load_err;
   logic              core_hold;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .fetch_pc     (fetch_pc),
      .fetch_instr  (fetch_instr),
      .load_busy    (load_busy),
      .load_done    (load_done),
      .load_err     (load_err),
      .core_hold    (core_hold),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       err;
      logic [8:0] wl;
      logic       hold;
   } done_t;

   done_t exp_q[$];
   done_t exp_e;
   int    n_cmp = 0;
   int    n_bad = 0;
   logic  prev_done = 1'b0;

   logic [7:0] img_a [0:5] = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h13, 8'h03};
   logic [7:0] img_d [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   int         gaps  [0:9] = '{1, 2, 0, 3, 1, 0, 2, 1, 3, 2};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      load_start = 1'b1;
      @(posedge clk);
      #1 load_start = 1'b0;
   endtask

   // Offer one byte after 'gap' idle cycles; in_ready must stay high through the gap.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         in_valid = 1'b0;
         chk("ready_in_gap", {31'b0, in_ready}, 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_accept_timeout: in_ready %b expected 1", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!load_done && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!load_done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: load_done %b expected 1", load_done);
      end
   endtask

   task automatic chk_fetch(input logic [7:0] pc, input logic [31:0] exp, input string nm);
      @(negedge clk);
      fetch_pc = pc;
      #1 chk(nm, fetch_instr, exp);
   endtask

   // Scoreboard monitor: every rising load_done consumes one expected outcome.
   always @(negedge clk) begin
      if (load_done && !prev_done) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_unexpected: load_done rose with no expected load");
         end else begin
            exp_e = exp_q.pop_front();
            chk("done_load_err", {31'b0, load_err}, {31'b0, exp_e.err});
            chk("done_words_loaded", {23'b0, words_loaded}, {23'b0, exp_e.wl});
            chk("done_core_hold", {31'b0, core_hold}, {31'b0, exp_e.hold});
         end
      end
      prev_done = load_done;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_load_busy", {31'b0, load_busy}, 32'd0);
      chk("rst_load_done", {31'b0, load_done}, 32'd0);
      chk("rst_load_err", {31'b0, load_err}, 32'd0);
      chk("rst_core_hold", {31'b0, core_hold}, 32'd1);
      chk("rst_words_loaded", {23'b0, words_loaded}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load A: one word, good checksum.
      exp_q.push_back(done_t'{1'b0, 9'd1, 1'b0});
      pulse_start();
      chk("a_busy_after_start", {31'b0, load_busy}, 32'd1);
      for (int i = 0; i < 6; i++) send_byte(img_a[i], 0);
      wait_done();
      chk("a_busy_in_done", {31'b0, load_busy}, 32'd0);
      chk_fetch(8'd0, 32'h00100013, "a_fetch_pc0");

      // Load B: start and header offered together in DONE; bad checksum.
      exp_q.push_back(done_t'{1'b1, 9'd1, 1'b1});
      @(negedge clk);
      load_start = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'h00;
      #1 chk("b_ready_in_done", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1 load_start = 1'b0;
      chk("b_done_cleared", {31'b0, load_done}, 32'd0);
      chk("b_ready_in_hdr", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 1; i < 5; i++) send_byte(img_a[i], 0);
      send_byte(8'hFF, 0);
      wait_done();
      chk_fetch(8'd0, 32'h00100013, "b_fetch_pc0");

      // Load C: full 256-word image, byte k = k[7:0], checksum 0.
      exp_q.push_back(done_t'{1'b0, 9'd256, 1'b0});
      pulse_start();
      send_byte(8'hFF, 0);
      for (int k = 0; k < 1024; k++) send_byte(8'(k), 0);
      send_byte(8'h00, 0);
      wait_done();
      chk_fetch(8'd255, 32'hFCFDFEFF, "c_fetch_pc255");
      chk_fetch(8'd1, 32'h04050607, "c_fetch_pc1");
      // Unsolicited byte in DONE is left unconsumed.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      #1 chk("c_ready_unsolicited", {31'b0, in_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1 chk("c_words_after_extra", {23'b0, words_loaded}, 32'd256);
      chk("c_done_after_extra", {31'b0, load_done}, 32'd1);
      in_valid = 1'b0;

      // Load D: two words with idle gaps between bytes; checksum 0x88.
      exp_q.push_back(done_t'{1'b0, 9'd2, 1'b0});
      pulse_start();
      send_byte(8'h01, gaps[0]);
      for (int i = 0; i < 8; i++) send_byte(img_d[i], gaps[i+1]);
      send_byte(8'h88, gaps[9]);
      wait_done();
      chk_fetch(8'd0, 32'h11223344, "d_fetch_pc0");
      chk_fetch(8'd1, 32'h55667788, "d_fetch_pc1");
      chk_fetch(8'd2, 32'h08090A0B, "d_fetch_pc2_untouched");

      // Load E: load_start mid-DATA is ignored; checksum of A0..A7 is 0x00.
      exp_q.push_back(done_t'{1'b0, 9'd2, 1'b0});
      pulse_start();
      send_byte(8'h01, 0);
      for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 0);
      pulse_start();
      chk("e_busy_after_ignored_start", {31'b0, load_busy}, 32'd1);
      chk("e_words_after_3_bytes", {23'b0, words_loaded}, 32'd0);
      send_byte(8'hA3, 0);
      chk("e_words_after_4_bytes", {23'b0, words_loaded}, 32'd1);
      for (int i = 4; i < 8; i++) send_byte(8'hA0 + 8'(i), 0);
      send_byte(8'h00, 0);
      wait_done();
      chk_fetch(8'd0, 32'hA0A1A2A3, "e_fetch_pc0");
      chk_fetch(8'd1, 32'hA4A5A6A7, "e_fetch_pc1");

      // Reset after five DATA bytes of a two-word load.
      pulse_start();
      send_byte(8'h01, 0);
      for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("r_in_ready", {31'b0, in_ready}, 32'd0);
      chk("r_core_hold", {31'b0, core_hold}, 32'd1);
      chk("r_load_busy", {31'b0, load_busy}, 32'd0);
      chk("r_words_loaded", {23'b0, words_loaded}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_fetch(8'd0, 32'hC0C1C2C3, "r_fetch_pc0");
      chk_fetch(8'd1, 32'hC4A5A6A7, "r_fetch_pc1_partial");

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
